capped_subtractor_pipe: RTL
===========================

// Module: capped_subtractor_pipe
// PURPOSE
//  Saturating (capped) two's-complement subtractor, out = sat(a - b), the inverse
//  counterpart of the capped adder used in the datapath.
//  Two-stage pipeline with valid/ready handshake on both sides.
//  Reports the saturation direction alongside each result.
//  Sits between the operand producer and the result consumer of the arithmetic path.
// PARAMETERS
//  BITWIDTH  32  operand/result width in bits, signed two's complement (>= 2)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous reset, active low
//  in_valid     in   1         operand pair valid
//  in_ready     out  1         pipeline can accept operands this cycle
//  a            in   BITWIDTH  minuend (signed)
//  b            in   BITWIDTH  subtrahend (signed)
//  out_valid    out  1         result valid
//  out_ready    in   1         consumer accepts result this cycle
//  out          out  BITWIDTH  saturated difference (signed)
//  out_sat_pos  out  1         result clamped to max positive, aligned with out
//  out_sat_neg  out  1         result clamped to min negative, aligned with out
//  sat_cnt      out  16        saturation event count (only with SAT_COUNT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids=0; out, out_sat_pos, out_sat_neg,
//    and sat_cnt = 0. in_ready=1 in the first cycle after reset release.
//  - Stall rule: adv = !out_valid | out_ready. Both stages advance only when adv=1.
//    in_ready = adv (combinational). Transfer in: in_valid & in_ready.
//    Transfer out: out_valid & out_ready.
//  - S1 (on adv): s1_valid <= in_valid.
//    If in_valid: s1_diff <= {a[MSB],a} - {b[MSB],b} (BITWIDTH+1 bits).
//  - S2 (on adv): out_valid <= s1_valid. If s1_valid, select on s1_diff[BW:BW-1]:
//    01 -> out={0,1..1}, sat_pos=1;  10 -> out={1,0..0}, sat_neg=1;
//    00/11 -> out=s1_diff[BW-1:0], both flags 0.
//  - Latency: 2 cycles, in-transfer edge to out_valid, with no backpressure.
//    Throughput: 1 result per cycle.
//  - Backpressure: while out_valid & !out_ready, S1/S2 contents hold.
//    No result is dropped or duplicated. Data on a, b is ignored when in_ready=0.
//  - Bubbles: with in_valid=0 and adv=1, a bubble (valid=0) propagates.
//    Data registers may keep stale values; flags are meaningful only with out_valid.
//  - Flags are mutually exclusive. out_sat_pos & out_sat_neg = 1 never occurs.
//  - Corner: a=min, b=min -> 0. a=0, b=min -> max positive (sat_pos).
//    a=min, b=1 -> min (sat_neg).
//  - Reset mid-operation: in-flight results are discarded; out_valid=0 immediately.
// CONFIGURATION
//  SAT_COUNT_EN defined:
//    - sat_cnt port exists.
//    - It increments by 1 on each out transfer with sat_pos|sat_neg.
//    - It sticks at 16'hFFFF and does not wrap.
//    - Cleared only by reset.
//  SAT_COUNT_EN undefined: no sat_cnt port and no counter logic.
//    All other behaviour is identical.
// TESTING (BITWIDTH=8, out_ready=1 unless stated)
//  1. a=100, b=-50 (150 overflows) -> out=127 (0x7F), sat_pos=1, sat_neg=0,
//     2 cycles later.
//  2. a=-100, b=50 (-150) -> out=-128 (0x80), sat_neg=1.
//     Then a=-128, b=-128 -> out=0, flags 0.
//  3. Back-to-back stream a=i, b=1 for i=0..9 with in_valid held high
//     -> out=-1..8 on 10 consecutive cycles.
//  4. Stream 5 ops, out_ready=0 for 4 cycles mid-stream -> in_ready=0 and out held
//     stable while stalled; all 5 results delivered in order, no duplicates.
//  5. rst_n pulsed low with 2 ops in flight -> out_valid drops in the same cycle;
//     those ops are never output; the next op has 2-cycle latency.
//  6. SAT_COUNT_EN: 3 saturating plus 2 normal ops -> sat_cnt=3.
//     Preload to 0xFFFE via 2 more saturating events -> stays 0xFFFF.

Source files
------------

// File: rtl/capped_subtractor_pipe.sv
// Two-stage saturating subtractor, out = sat(a - b), with valid/ready handshake on both sides.
// Optional saturation event counter (sat_cnt) is built when SAT_COUNT_EN is defined.
module capped_subtractor_pipe #(
  parameter int BITWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] a,
  input  logic signed [BITWIDTH-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out,
  output logic                       out_sat_pos,
  output logic                       out_sat_neg
`ifdef SAT_COUNT_EN
  ,
  output logic [15:0]                sat_cnt
`endif
);

  typedef struct packed {
    logic [BITWIDTH-1:0] val;
    logic                pos;
    logic                neg;
  } sat_t;

  // The top two bits of the widened difference disagree exactly when it overflowed.
  function automatic sat_t saturate(input logic signed [BITWIDTH:0] d);
    sat_t r;
    r.val = d[BITWIDTH-1:0];
    r.pos = 1'b0;
    r.neg = 1'b0;
    case (d[BITWIDTH -: 2])
      2'b01: begin
        r.val = {1'b0, {(BITWIDTH-1){1'b1}}};
        r.pos = 1'b1;
      end
      2'b10: begin
        r.val = {1'b1, {(BITWIDTH-1){1'b0}}};
        r.neg = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  logic                     adv;
  logic                     vld_p1;
  logic signed [BITWIDTH:0] diff_p1;
  sat_t                     res_p1;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign res_p1   = saturate(diff_p1);

  // Stage 1: widened difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      diff_p1 <= $signed({a[BITWIDTH-1], a}) - $signed({b[BITWIDTH-1], b});
    end
  end

  // Stage 2: clamp and flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out         <= '0;
      out_sat_pos <= 1'b0;
      out_sat_neg <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out         <= res_p1.val;
        out_sat_pos <= res_p1.pos;
        out_sat_neg <= res_p1.neg;
      end
    end
  end

`ifdef SAT_COUNT_EN
  // Counts saturated results as they leave; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= 16'd0;
    end else if (out_valid && out_ready && (out_sat_pos || out_sat_neg) &&
                 (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule
